// File: rtl/mux_arbiter_pkg.sv
// Shared constants, FSM state type and a one-hot helper for the 4-way mux arbiter.
package mux_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
  import mux_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Scan from farthest to nearest offset so the nearest set bit wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter_4.sv
// Round-robin arbiter for four requesters driving a shared 4:1 data mux with valid/ready handoff.
// Optional MUX_ARBITER_LOCK_EN adds a lock input that keeps the grant across handshakes.
module mux_arbiter_4
  import mux_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic                          out_ready,
`ifdef MUX_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]            lock,
`endif
  output logic [NUM_REQ-1:0]            gnt,
  output logic [SEL_W-1:0]              sel,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [NUM_REQ-1:0]            ack
);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;

  logic                 hs_c;
  logic                 lock_hold_c;
  logic [SEL_W-1:0]     pick_ptr_c;
  logic                 pick_any;
  logic [SEL_W-1:0]     pick_idx;

  assign out_valid = (state_q == GRANT);
  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign hs_c      = out_valid & out_ready;

`ifdef MUX_ARBITER_LOCK_EN
  assign lock_hold_c = lock[sel_q] & req[sel_q];
`else
  assign lock_hold_c = 1'b0;
`endif

  // While granting, the candidate pointer is the one a handshake would install.
  assign pick_ptr_c = (state_q == GRANT) ? SEL_W'(sel_q + SEL_W'(1)) : ptr_q;

  rr_pick4 u_pick (
    .req (req),
    .ptr (pick_ptr_c),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          gnt_d   = onehot(pick_idx);
        end
      end
      GRANT: begin
        if (hs_c) begin
          if (!lock_hold_c) begin
            ptr_d = pick_ptr_c;
            if (pick_any) begin
              sel_d = pick_idx;
              gnt_d = onehot(pick_idx);
            end else begin
              state_d = IDLE;
              gnt_d   = '0;
            end
          end
        end else if (!req[sel_q]) begin
          // Requester withdrew before being served: drop without advancing ptr.
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    out_data = '0;
    ack      = '0;
    if (out_valid) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (sel_q == SEL_W'(i)) begin
          out_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (out_ready) begin
        ack = onehot(sel_q);
      end
    end
  end

endmodule

// File: tb/tb_mux_arbiter_4.sv
// Directed, table-driven bench for mux_arbiter_4 with hand-written reset/fairness/lock sequences.
module tb_mux_arbiter_4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] in_data;
  logic        out_ready;
`ifdef MUX_ARBITER_LOCK_EN
  logic [3:0]  lock;
`endif
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [3:0]  ack;

  int unsigned passed = 0;
  int unsigned total  = 0;

  mux_arbiter_4 #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .out_ready (out_ready),
`ifdef MUX_ARBITER_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ack       (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [7:0] data;
    logic [3:0] ack;
  } vec_t;

  vec_t       vecs[18];
  logic [7:0] slice_val[4];
  int         order[5];

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es,
                       input logic cs, input logic ev, input logic [7:0] ed, input logic [3:0] ea);
    total++;
    if (gnt !== eg || (cs && sel !== es) || out_valid !== ev || out_data !== ed || ack !== ea)
      $display("FAIL %s: got gnt=%b sel=%0d valid=%b data=%h ack=%b, want gnt=%b sel=%0d valid=%b data=%h ack=%b",
               name, gnt, sel, out_valid, out_data, ack, eg, es, ev, ed, ea);
    else
      passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    slice_val = '{8'h10, 8'h21, 8'hA5, 8'h3C};
    order     = '{0, 1, 2, 3, 0};

    vecs[0]  = '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 8'h00, 4'b0000};
    vecs[1]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA5, 4'b0100};
    vecs[2]  = '{4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 8'hA5, 4'b0000};
    vecs[3]  = '{4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00, 4'b0000};
    vecs[4]  = '{4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1, 8'h3C, 4'b1000};
    vecs[5]  = '{4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h10, 4'b0001};
    vecs[6]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 8'h00, 4'b0000};
    vecs[7]  = '{4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00, 4'b0000};
    vecs[8]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 8'h21, 4'b0000};
    vecs[9]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 8'h21, 4'b0000};
    vecs[10] = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 8'h21, 4'b0000};
    vecs[11] = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 8'h21, 4'b0000};
    vecs[12] = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 8'h21, 4'b0000};
    vecs[13] = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 8'h21, 4'b0010};
    vecs[14] = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 8'hA5, 4'b0000};
    vecs[15] = '{4'b1011, 1'b0, 4'b0100, 2'd2, 1'b1, 8'hA5, 4'b0000};
    vecs[16] = '{4'b0110, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00, 4'b0000};
    vecs[17] = '{4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 8'hA5, 4'b0000};

    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    in_data   = {8'h3C, 8'hA5, 8'h21, 8'h10};
`ifdef MUX_ARBITER_LOCK_EN
    lock      = 4'b0000;
`endif

    #2;
    check("reset_state", 4'b0000, 2'd0, 1'b1, 1'b0, 8'h00, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, wrap, empty handshake, backpressure, withdrawal.
    for (int i = 0; i < 18; i++) begin
      req       = vecs[i].req;
      out_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].valid,
            vecs[i].valid, vecs[i].data, vecs[i].ack);
      @(negedge clk);
    end

    // Fairness from reset: all requesting, always ready.
    rst_n = 1'b0;
    #1;
    rst_n     = 1'b1;
    req       = 4'b1111;
    out_ready = 1'b1;
    #1;
    check("fair_idle", 4'b0000, 2'd0, 1'b1, 1'b0, 8'h00, 4'b0000);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("fair%0d", k), 4'(1 << order[k]), 2'(order[k]), 1'b1, 1'b1,
            slice_val[order[k]], 4'(1 << order[k]));
      @(negedge clk);
    end

    // Async reset mid-grant, then first grant after release starts from ptr 0.
    rst_n = 1'b0;
    #1;
    rst_n     = 1'b1;
    req       = 4'b0100;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("pre_reset_grant", 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 4'b0000, 2'd0, 1'b1, 1'b0, 8'h00, 4'b0000);
    @(negedge clk);
    rst_n     = 1'b1;
    req       = 4'b1111;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    check("post_reset_ptr0", 4'b0001, 2'd0, 1'b1, 1'b1, 8'h10, 4'b0000);
    @(negedge clk);

`ifdef MUX_ARBITER_LOCK_EN
    rst_n = 1'b0;
    #1;
    rst_n     = 1'b1;
    lock      = 4'b0001;
    req       = 4'b0011;
    out_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("lock_hold%0d", k), 4'b0001, 2'd0, 1'b1, 1'b1, 8'h10, 4'b0001);
      @(negedge clk);
    end
    lock = 4'b0000;
    #1;
    check("lock_release", 4'b0001, 2'd0, 1'b1, 1'b1, 8'h10, 4'b0001);
    @(negedge clk);
    #1;
    check("lock_next", 4'b0010, 2'd1, 1'b1, 1'b1, 8'h21, 4'b0010);
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mux_arbiter_4.md
MUX_ARBITER_4 -- requirements
Module: mux_arbiter_4

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each requester's data word and of out_data.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  4  per-requester request; bit i = requester i.
REQ-006 in_data  input  4*DATA_WIDTH  requester data; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 out_ready  input  1  downstream accepts out_data this cycle.
REQ-008 gnt  output  4  one-hot registered grant, all-zero when idle.
REQ-009 sel  output  2  registered index of granted requester, for driving the shared 4:1 mux.
REQ-010 out_valid  output  1  high while a grant is held.
REQ-011 out_data  output  DATA_WIDTH  in_data slice selected by sel; 0 when out_valid low.
REQ-012 ack  output  4  one-hot, combinational: ack[sel] = out_valid & out_ready.

Function
REQ-013 FSM states SHALL be IDLE and GRANT only.
REQ-014 IDLE: if req != 0, the winner SHALL be registered into gnt/sel at the next clk edge, FSM to GRANT (1-cycle request-to-grant latency).
REQ-015 Winner SHALL be the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-016 GRANT: out_valid=1, out_data = in_data slice [sel], combinational from registered sel.
REQ-017 Handshake = out_valid & out_ready; on it ptr SHALL become sel+1 modulo 4 (3 wraps to 0).
REQ-018 On handshake with any req bit set (ack'd requester included), the block SHALL re-arbitrate using the updated ptr and stay in GRANT with the new winner at the next edge (back-to-back, no idle cycle).
REQ-019 On handshake with req == 0, FSM SHALL go to IDLE, gnt=0, out_valid=0 next cycle.
REQ-020 If req[sel] deasserts in GRANT without handshake, the grant SHALL be dropped (IDLE next cycle), ptr unchanged.
REQ-021 Grant SHALL NOT change while out_valid=1 and out_ready=0 and req[sel]=1 (no preemption).
REQ-022 gnt SHALL be one-hot or zero at all times; gnt != 0 iff out_valid.

Reset
REQ-023 On rst_n low, immediately: state=IDLE, gnt=0, sel=0, ptr=0, out_valid=0, out_data=0, ack=0.
REQ-024 Reset asserted mid-transfer SHALL abandon the grant with no ack; first grant after release uses ptr=0.

Configuration
REQ-025 Macro MUX_ARBITER_LOCK_EN: when defined, a 4-bit input lock is added; on handshake with lock[sel]=1 and req[sel]=1, grant SHALL remain on sel and ptr SHALL NOT advance.
REQ-026 Without MUX_ARBITER_LOCK_EN the lock port SHALL NOT exist and every handshake advances ptr per REQ-017.

Structure
REQ-027 Package mux_arbiter_pkg SHALL hold NUM_REQ=4, SEL_W=2 and the state enum type (IDLE, GRANT).
REQ-028 Sub-module rr_pick4 SHALL be the combinational rotating priority picker: inputs req[3:0], ptr[1:0]; outputs any, idx[1:0].

Verification
REQ-029 Single requester: req=4'b0100, in_data slice2=8'hA5, out_ready=1 -> gnt=4'b0100, sel=2, out_data=8'hA5 one cycle after req; ack[2] pulses; ptr=3.
REQ-030 Fairness: req=4'b1111 held, out_ready=1 from reset -> grant order 0,1,2,3,0 on consecutive cycles, no idle gaps.
REQ-031 Backpressure: grant to 1, out_ready=0 for 5 cycles with req=4'b1111 -> gnt stays 4'b0010, ack=0; on out_ready=1 next grant is 2.
REQ-032 Wrap: ptr=3, req=4'b1001 -> grant 3, then 0 after handshake.
REQ-033 Withdrawal and reset: req[1] dropped mid-grant -> IDLE next cycle, ptr unchanged; rst_n low mid-grant -> gnt=0, out_valid=0 without waiting for clk.
REQ-034 With MUX_ARBITER_LOCK_EN: lock=4'b0001, req=4'b0011 -> requester 0 holds grant across 3 handshakes; lock cleared -> next grant is 1.
